// File: rtl/m_dram_responder.sv
// ---- m_dram_responder: fixed-latency block-RAM word memory behind the w_dram_* interface ----
// ---- rev 1.0 ----------------------------------------------------------------------------------
`default_nettype none

module m_dram_responder #(
  parameter int ADDR_W         = 14,
  parameter int LATENCY        = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic [31:0] w_dram_addr,
  input  logic [31:0] w_dram_wdata,
  input  logic        w_dram_we_t,
  input  logic        w_dram_le,
  input  logic [2:0]  w_dram_ctrl,
  output logic        w_dram_busy,
  output logic [31:0] w_dram_odata,
  output logic        w_init_done,
  output logic        w_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  localparam state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  logic [31:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              init_done_q, init_done_d;
  logic              err_q, err_d;
  logic [31:0]       odata_q, odata_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic              store_q, store_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_widx;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic [31:0]       load_val;
  logic [31:0]       store_val;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic              strobe;
  logic              ctrl_q_bad;
  logic              ctrl_in_bad;
  logic              unused_addr_bits;

  assign strobe           = w_dram_le | w_dram_we_t;
  assign mem_rdata        = mem[widx_q];
  assign ctrl_q_bad       = (ctrl_q == 3'b011) || (ctrl_q[2:1] == 2'b11);
  assign ctrl_in_bad      = (w_dram_ctrl == 3'b011) || (w_dram_ctrl[2:1] == 2'b11);
  assign unused_addr_bits = ^w_dram_addr[31:ADDR_W+2];

  // Lane extraction for loads and lane merge for stores, both from the word read at completion.
  always_comb begin
    byte_sel  = mem_rdata[{lane_q, 3'b000} +: 8];
    half_sel  = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    load_val  = mem_rdata;
    store_val = mem_rdata;
    if (!ctrl_q_bad) begin
      case (ctrl_q[1:0])
        2'b00: begin
          load_val = ctrl_q[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
          store_val[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end
        2'b01: begin
          load_val = ctrl_q[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
          store_val[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
        default: store_val = wdata_q;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    odata_d     = odata_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    clr_idx_d   = clr_idx_q;
    widx_d      = widx_q;
    lane_d      = lane_q;
    ctrl_d      = ctrl_q;
    store_d     = store_q;
    mem_we      = 1'b0;
    mem_widx    = widx_q;
    mem_wdata   = store_val;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_widx  = clr_idx_q;
        mem_wdata = 32'b0;
        clr_idx_d = clr_idx_q + 1'b1;
        if (strobe) err_d = 1'b1;
        if (clr_idx_q == '1) begin
          busy_d      = 1'b0;
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_IDLE: begin
        init_done_d = 1'b1;
        if (strobe) begin
          widx_d  = w_dram_addr[ADDR_W+1:2];
          lane_d  = w_dram_addr[1:0];
          wdata_d = w_dram_wdata;
          ctrl_d  = w_dram_ctrl;
          store_d = w_dram_we_t;
          busy_d  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = S_BUSY;
          if ((w_dram_le & w_dram_we_t) | ctrl_in_bad) err_d = 1'b1;
        end
      end
      S_BUSY: begin
        if (strobe) err_d = 1'b1;
        if (cnt_q == 4'd0) begin
          if (store_q) mem_we = 1'b1;
          else         odata_d = load_val;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q     <= RST_STATE;
      busy_q      <= CLEAR_ON_RESET;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      odata_q     <= 32'b0;
      wdata_q     <= 32'b0;
      cnt_q       <= 4'b0;
      clr_idx_q   <= '0;
      widx_q      <= '0;
      lane_q      <= 2'b0;
      ctrl_q      <= 3'b0;
      store_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      odata_q     <= odata_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      clr_idx_q   <= clr_idx_d;
      widx_q      <= widx_d;
      lane_q      <= lane_d;
      ctrl_q      <= ctrl_d;
      store_q     <= store_d;
    end
  end

  // Memory has no reset; writes are suppressed while reset is held so an aborted store never lands.
  always_ff @(posedge CLK) begin
    if (mem_we && RST_X) mem[mem_widx] <= mem_wdata;
  end

  assign w_dram_busy  = busy_q;
  assign w_dram_odata = odata_q;
  assign w_init_done  = init_done_q;
  assign w_err        = err_q;

endmodule

`default_nettype wire
